// File: rtl/tri_setup_dispatch_pkg.sv
// Shared types for the triangle setup front end: vertex/setup records,
// cull modes and the dispatcher state encoding.
package celery_pkg;

  localparam int CNT_W_DEF = 32;

  // Coordinates are FP16.16.
  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
  } vertex_t;

  typedef struct packed {
    logic               valid;
    logic               ccw;
    logic signed [31:0] area;
    logic [15:0]        min_x;
    logic [15:0]        min_y;
    logic [15:0]        max_x;
    logic [15:0]        max_y;
  } triangle_setup_t;

  typedef enum logic [1:0] {
    CULL_NONE = 2'd0,
    CULL_CW   = 2'd1,
    CULL_CCW  = 2'd2
  } cull_mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_HOLD
  } state_t;

  // Mode 3 falls through both terms and so behaves like CULL_NONE.
  function automatic logic cull_drop(triangle_setup_t s, logic [1:0] mode, logic skip_degen);
    return (skip_degen && !s.valid) ||
           (mode == CULL_CW && !s.ccw) ||
           (mode == CULL_CCW && s.ccw);
  endfunction

endpackage

// File: rtl/tri_setup_dispatch.sv
// Sequences one triangle at a time through triangle_setup, culls the result
// and hands survivors to the rasterizer through a one-entry output buffer.
module tri_setup_dispatch
  import celery_pkg::*;
#(
  parameter int CNT_W           = CNT_W_DEF,
  parameter bit SKIP_DEGENERATE = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tri_valid,
  output logic            tri_ready,
  input  vertex_t         tri_v0,
  input  vertex_t         tri_v1,
  input  vertex_t         tri_v2,
  output vertex_t         su_v0,
  output vertex_t         su_v1,
  output vertex_t         su_v2,
  output logic            su_start,
  input  logic            su_done,
  input  logic            su_busy,
  input  triangle_setup_t su_setup,
  input  logic [1:0]      cull_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output triangle_setup_t out_setup,
  output logic            busy,
  input  logic            stat_clear,
  output logic [CNT_W-1:0] stat_accepted,
  output logic [CNT_W-1:0] stat_culled,
  output logic [CNT_W-1:0] stat_emitted
);

  state_t state;
  logic   accept, drop, buf_free, emit, cull_hit;

  assign tri_ready = (state == S_IDLE);
  assign accept    = tri_valid && tri_ready;
  assign drop      = cull_drop(su_setup, cull_mode, SKIP_DEGENERATE);
  assign emit      = out_valid && out_ready;
  assign buf_free  = !out_valid || out_ready;
  assign cull_hit  = (state == S_WAIT) && su_done && drop;
  assign busy      = (state != S_IDLE) || out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      su_v0     <= '0;
      su_v1     <= '0;
      su_v2     <= '0;
      su_start  <= 1'b0;
      out_valid <= 1'b0;
      out_setup <= '0;
    end else begin
      su_start <= 1'b0;
      // A load in the same cycle overrides this clear.
      if (emit) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            su_v0    <= tri_v0;
            su_v1    <= tri_v1;
            su_v2    <= tri_v2;
            su_start <= !su_busy;
            state    <= S_LAUNCH;
          end
        end
        // Start goes out on entry unless the setup unit was still busy;
        // then it is issued as soon as busy drops.
        S_LAUNCH: begin
          if (su_start)      state    <= S_WAIT;
          else if (!su_busy) su_start <= 1'b1;
        end
        S_WAIT: begin
          if (su_done) begin
            if (drop) begin
              state <= S_IDLE;
            end else if (buf_free) begin
              out_setup <= su_setup;
              out_valid <= 1'b1;
              state     <= S_IDLE;
            end else begin
              state <= S_HOLD;
            end
          end
        end
        // Only survivors reach here; su_setup is still held by the setup unit.
        S_HOLD: begin
          if (buf_free) begin
            out_setup <= su_setup;
            out_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_accepted <= '0;
      stat_culled   <= '0;
      stat_emitted  <= '0;
    end else if (stat_clear) begin
      stat_accepted <= '0;
      stat_culled   <= '0;
      stat_emitted  <= '0;
    end else begin
      if (accept)   stat_accepted <= stat_accepted + CNT_W'(1);
      if (cull_hit) stat_culled   <= stat_culled + CNT_W'(1);
      if (emit)     stat_emitted  <= stat_emitted + CNT_W'(1);
    end
  end

endmodule
